// File: rtl/array_port_pkg.sv
// Shared widths and state encoding for the SRAM RW-port controller.
package array_port_pkg;

    localparam int unsigned ADDR_W    = 7;
    localparam int unsigned DATA_W    = 44;
    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_W    = DATA_W / NUM_LANES;
    localparam int unsigned DEPTH     = 1 << ADDR_W;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } state_e;

endpackage

// File: rtl/array_port_ctrl_if.sv
// Request/response channels plus the SRAM RW-port bundle.
// master: the controller side; slave: requesters and the array macro.
interface array_port_ctrl_if;
    import array_port_pkg::*;

    logic                 wr_valid;
    logic                 wr_ready;
    logic [ADDR_W-1:0]    wr_addr;
    logic [NUM_LANES-1:0] wr_mask;
    logic [DATA_W-1:0]    wr_data;

    logic                 rd_valid;
    logic                 rd_ready;
    logic [ADDR_W-1:0]    rd_addr;

    logic                 resp_valid;
    logic                 resp_ready;
    logic [DATA_W-1:0]    resp_data;

    logic                 init_done;

    logic                 sram_en;
    logic                 sram_wmode;
    logic [ADDR_W-1:0]    sram_addr;
    logic [NUM_LANES-1:0] sram_wmask;
    logic [DATA_W-1:0]    sram_wdata;
    logic [DATA_W-1:0]    sram_rdata;

    modport master (
        input  wr_valid, wr_addr, wr_mask, wr_data,
        input  rd_valid, rd_addr, resp_ready, sram_rdata,
        output wr_ready, rd_ready, resp_valid, resp_data, init_done,
        output sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata
    );

    modport slave (
        output wr_valid, wr_addr, wr_mask, wr_data,
        output rd_valid, rd_addr, resp_ready, sram_rdata,
        input  wr_ready, rd_ready, resp_valid, resp_data, init_done,
        input  sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata
    );

endinterface

// File: rtl/array_resp_fifo.sv
// 2-entry in-order read-response buffer with valid/ready output.
// Ports: clock, reset_n; push/push_data in; ready in, valid/data out
// (head entry); count = occupancy. The caller guarantees no push when full
// unless the head is popped in the same cycle.
module array_resp_fifo
    import array_port_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem_q [2];
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic [1:0]        count_q;
    logic              pop;

    assign valid = (count_q != 2'd0);
    assign pop   = valid & ready;
    assign data  = mem_q[rd_ptr_q];
    assign count = count_q;

    // Storage, pointers and occupancy
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/array_port_ctrl.sv
// Single-RW-port SRAM controller: zero-init sweep after reset, then
// read/write arbitration onto the one port with read-credit flow control
// into a 2-entry response buffer.
// Ports: clock, reset_n (async, active-low); bus (master modport) carrying
// the write/read request channels, read response channel, init_done and
// the SRAM RW-port signals.
module array_port_ctrl
    import array_port_pkg::*;
#(
    parameter bit SHOULD_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    array_port_ctrl_if.master bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              prio_q, prio_d;
    logic              inflight_q, inflight_d;

    logic              grant_rd, grant_wr;
    logic              rd_elig;
    logic              pop;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic [1:0]        fifo_count;

    assign pop = resp_valid & bus.resp_ready;

    // Credit: buffered + in-flight reads, less the one leaving now, must stay below 2
    assign rd_elig = bus.rd_valid &&
                     ((3'(fifo_count) + 3'(inflight_q)) < (3'd2 + 3'(pop)));

    assign bus.resp_valid = resp_valid;
    assign bus.resp_data  = resp_data;

    // State, sweep counter, arbitration priority and read-in-flight flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= SHOULD_RESET ? INIT : IDLE;
            cnt_q      <= '0;
            prio_q     <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prio_q     <= prio_d;
            inflight_q <= inflight_d;
        end
    end

    // Next state, arbitration and RW-port drive; everything held low in reset
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        prio_d         = prio_q;
        inflight_d     = 1'b0;
        grant_rd       = 1'b0;
        grant_wr       = 1'b0;
        bus.wr_ready   = 1'b0;
        bus.rd_ready   = 1'b0;
        bus.init_done  = 1'b0;
        bus.sram_en    = 1'b0;
        bus.sram_wmode = 1'b0;
        bus.sram_addr  = '0;
        bus.sram_wmask = '0;
        bus.sram_wdata = '0;

        if (reset_n) begin
            unique case (state_q)
                INIT: begin
                    bus.sram_en    = 1'b1;
                    bus.sram_wmode = 1'b1;
                    bus.sram_addr  = cnt_q;
                    bus.sram_wmask = '1;
                    cnt_d          = cnt_q + ADDR_W'(1);
                    if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = IDLE;
                    end
                end
                IDLE: begin
                    bus.init_done = 1'b1;
                    grant_rd      = rd_elig && (!bus.wr_valid || !prio_q);
                    grant_wr      = bus.wr_valid && (!rd_elig || prio_q);
                    if (rd_elig && bus.wr_valid) begin
                        prio_d = ~prio_q;
                    end
                    inflight_d   = grant_rd;
                    bus.rd_ready = grant_rd;
                    bus.wr_ready = grant_wr;
                    if (grant_wr) begin
                        bus.sram_en    = 1'b1;
                        bus.sram_wmode = 1'b1;
                        bus.sram_addr  = bus.wr_addr;
                        bus.sram_wmask = bus.wr_mask;
                        bus.sram_wdata = bus.wr_data;
                    end else if (grant_rd) begin
                        bus.sram_en   = 1'b1;
                        bus.sram_addr = bus.rd_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    // Array data arrives the cycle after the read enable
    array_resp_fifo u_resp_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (inflight_q),
        .push_data (bus.sram_rdata),
        .ready     (bus.resp_ready),
        .valid     (resp_valid),
        .data      (resp_data),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_array_port_ctrl.sv
// Directed bench for array_port_ctrl with a behavioural 128x44 masked SRAM.
module tb_array_port_ctrl;
    import array_port_pkg::*;

    logic clock;
    logic reset_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    array_port_ctrl_if bus ();

    array_port_ctrl #(.SHOULD_RESET(1'b1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Array macro model: masked write, 1-cycle registered read
    logic [DATA_W-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = 44'hDEA_DBEE_F000 | 44'(i);
    end
    always @(posedge clock) begin
        if (bus.sram_en) begin
            if (bus.sram_wmode) begin
                for (int l = 0; l < int'(NUM_LANES); l++)
                    if (bus.sram_wmask[l]) mem[bus.sram_addr][l*LANE_W +: LANE_W] <= bus.sram_wdata[l*LANE_W +: LANE_W];
            end else begin
                bus.sram_rdata <= mem[bus.sram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_r;
        reset_n        = 1'b0;
        bus.wr_valid   = 1'b1;
        bus.wr_addr    = '0;
        bus.wr_mask    = '0;
        bus.wr_data    = '0;
        bus.rd_valid   = 1'b1;
        bus.rd_addr    = '0;
        bus.resp_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        #1;
        chk("rst_sram_en",    64'(bus.sram_en), 64'd0);
        chk("rst_wr_ready",   64'(bus.wr_ready), 64'd0);
        chk("rst_rd_ready",   64'(bus.rd_ready), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_data",  64'(bus.resp_data), 64'd0);
        chk("rst_init_done",  64'(bus.init_done), 64'd0);

        // Zero-init sweep: 128 write cycles, requests refused
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 128; i++) begin
            #1;
            chk("init_en",    64'(bus.sram_en), 64'd1);
            chk("init_wmode", 64'(bus.sram_wmode), 64'd1);
            chk("init_addr",  64'(bus.sram_addr), 64'(i));
            chk("init_wmask", 64'(bus.sram_wmask), 64'hF);
            chk("init_wdata", 64'(bus.sram_wdata), 64'd0);
            chk("init_rdy",   64'({bus.rd_ready, bus.wr_ready}), 64'd0);
            chk("init_done0", 64'(bus.init_done), 64'd0);
            @(negedge clock);
        end
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b0;
        #1;
        chk("init_done1",  64'(bus.init_done), 64'd1);
        chk("idle_en",     64'(bus.sram_en), 64'd0);

        // Read addr 5 after sweep
        @(negedge clock);
        bus.rd_valid = 1'b1; bus.rd_addr = 7'd5; bus.resp_ready = 1'b1;
        #1;
        chk("rd5_ready", 64'(bus.rd_ready), 64'd1);
        chk("rd5_port",  64'({bus.sram_en, bus.sram_wmode, bus.sram_wmask}), 64'b10_0000);
        chk("rd5_addr",  64'(bus.sram_addr), 64'd5);
        @(negedge clock);
        bus.rd_valid = 1'b0;
        #1 chk("rd5_n1_valid", 64'(bus.resp_valid), 64'd0);
        @(negedge clock);
        #1;
        chk("rd5_n2_valid", 64'(bus.resp_valid), 64'd1);
        chk("rd5_data",     64'(bus.resp_data), 64'd0);
        @(negedge clock);
        #1 chk("rd5_drained", 64'(bus.resp_valid), 64'd0);

        // Full write then read-after-write
        @(negedge clock);
        bus.wr_valid = 1'b1; bus.wr_addr = 7'h10; bus.wr_mask = 4'b1111; bus.wr_data = 44'h0AB_CDE1_2345;
        #1;
        chk("wr_ready", 64'(bus.wr_ready), 64'd1);
        chk("wr_port",  64'({bus.sram_en, bus.sram_wmode, bus.sram_wmask}), 64'b11_1111);
        chk("wr_addr",  64'(bus.sram_addr), 64'h10);
        chk("wr_wdata", 64'(bus.sram_wdata), 64'h0AB_CDE1_2345);
        @(negedge clock);
        bus.wr_valid = 1'b0; bus.rd_valid = 1'b1; bus.rd_addr = 7'h10;
        #1 chk("raw_rd_ready", 64'(bus.rd_ready), 64'd1);
        @(negedge clock);
        bus.rd_valid = 1'b0;
        #1 chk("raw_n1_valid", 64'(bus.resp_valid), 64'd0);
        @(negedge clock);
        #1;
        chk("raw_valid", 64'(bus.resp_valid), 64'd1);
        chk("raw_data",  64'(bus.resp_data), 64'h0AB_CDE1_2345);

        // Lane-1 masked write of all-ones, read back
        @(negedge clock);
        bus.wr_valid = 1'b1; bus.wr_mask = 4'b0010; bus.wr_data = '1;
        #1 chk("mwr_wmask", 64'(bus.sram_wmask), 64'b0010);
        @(negedge clock);
        bus.wr_valid = 1'b0; bus.rd_valid = 1'b1; bus.rd_addr = 7'h10;
        #1 chk("mrd_ready", 64'(bus.rd_ready), 64'd1);
        @(negedge clock);
        bus.rd_valid = 1'b0;
        @(negedge clock);
        #1 chk("mrd_data", 64'(bus.resp_data), 64'h0AB_CDFF_FB45);

        // Backpressure: two reads fill the credits, writes still pass
        @(negedge clock);
        bus.resp_ready = 1'b0; bus.rd_valid = 1'b1; bus.rd_addr = 7'h10;
        #1 chk("bp_rd0", 64'(bus.rd_ready), 64'd1);
        @(negedge clock);
        bus.rd_addr = 7'd5;
        #1 chk("bp_rd1", 64'(bus.rd_ready), 64'd1);
        @(negedge clock);
        #1;
        chk("bp_rd2_blocked", 64'(bus.rd_ready), 64'd0);
        chk("bp_rd2_en",      64'(bus.sram_en), 64'd0);
        @(negedge clock);
        bus.wr_valid = 1'b1; bus.wr_addr = 7'h20; bus.wr_mask = 4'hF; bus.wr_data = 44'h123;
        #1;
        chk("bp_rd3_blocked", 64'(bus.rd_ready), 64'd0);
        chk("bp_wr_ready",    64'(bus.wr_ready), 64'd1);
        chk("bp_head_valid",  64'(bus.resp_valid), 64'd1);
        chk("bp_head_data",   64'(bus.resp_data), 64'h0AB_CDFF_FB45);
        @(negedge clock);
        bus.wr_valid = 1'b0; bus.resp_ready = 1'b1; bus.rd_addr = 7'h20;
        #1;
        chk("bp_resume_rd", 64'(bus.rd_ready), 64'd1);
        chk("bp_resp0",     64'(bus.resp_data), 64'h0AB_CDFF_FB45);
        @(negedge clock);
        bus.rd_valid = 1'b0;
        #1;
        chk("bp_resp1_valid", 64'(bus.resp_valid), 64'd1);
        chk("bp_resp1",       64'(bus.resp_data), 64'd0);
        @(negedge clock);
        #1;
        chk("bp_resp2_valid", 64'(bus.resp_valid), 64'd1);
        chk("bp_resp2",       64'(bus.resp_data), 64'h123);
        @(negedge clock);
        #1 chk("bp_empty", 64'(bus.resp_valid), 64'd0);

        // Conflicting requests alternate R, W, R, W
        exp_r = 4'b0101;
        @(negedge clock);
        bus.rd_valid = 1'b1; bus.rd_addr = 7'h10;
        bus.wr_valid = 1'b1; bus.wr_addr = 7'h30; bus.wr_data = 44'h456; bus.wr_mask = 4'hF;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("arb_rd", 64'(bus.rd_ready), 64'(exp_r[k]));
            chk("arb_wr", 64'(bus.wr_ready), 64'(!exp_r[k]));
            chk("arb_wmode", 64'(bus.sram_wmode), 64'(!exp_r[k]));
            @(negedge clock);
        end
        bus.rd_valid = 1'b0; bus.wr_valid = 1'b0;
        #1;
        chk("arb_last_valid", 64'(bus.resp_valid), 64'd1);
        chk("arb_last_data",  64'(bus.resp_data), 64'h0AB_CDFF_FB45);
        @(negedge clock);
        #1 chk("arb_empty", 64'(bus.resp_valid), 64'd0);

        // Reset in IDLE, then again during the sweep at counter 60
        @(negedge clock);
        reset_n = 1'b0;
        #1 chk("rst2_done", 64'(bus.init_done), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (60) @(negedge clock);
        #1 chk("sweep_at60", 64'(bus.sram_addr), 64'd60);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_en",   64'(bus.sram_en), 64'd0);
        chk("mid_rst_addr", 64'(bus.sram_addr), 64'd0);
        chk("mid_rst_done", 64'(bus.init_done), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("restart_en",   64'(bus.sram_en), 64'd1);
        chk("restart_addr", 64'(bus.sram_addr), 64'd0);
        repeat (128) @(negedge clock);
        #1 chk("resweep_done", 64'(bus.init_done), 64'd1);

        // Address 0x30 was written before the re-sweep; must read back zero
        @(negedge clock);
        bus.rd_valid = 1'b1; bus.rd_addr = 7'h30;
        @(negedge clock);
        bus.rd_valid = 1'b0;
        @(negedge clock);
        #1 chk("resweep_0x30", 64'(bus.resp_data), 64'd0);

        // Reset with a read in flight: nothing stale afterwards
        @(negedge clock);
        bus.rd_valid = 1'b1; bus.rd_addr = 7'h10;
        #1 chk("if_rd_ready", 64'(bus.rd_ready), 64'd1);
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        chk("if_rst_rd_ready", 64'(bus.rd_ready), 64'd0);
        chk("if_rst_en",       64'(bus.sram_en), 64'd0);
        chk("if_rst_valid",    64'(bus.resp_valid), 64'd0);
        @(negedge clock);
        #1 chk("if_rst_valid2", 64'(bus.resp_valid), 64'd0);
        @(negedge clock);
        reset_n = 1'b1; bus.rd_valid = 1'b0;
        #1;
        chk("if_rel_addr",  64'(bus.sram_addr), 64'd0);
        chk("if_rel_valid", 64'(bus.resp_valid), 64'd0);
        @(negedge clock);
        #1;
        chk("if_rel_addr1",  64'(bus.sram_addr), 64'd1);
        chk("if_rel_valid1", 64'(bus.resp_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/array_port_ctrl.md
# array_port_ctrl

Initiator-side controller for a single-port 128 x 44 SRAM macro with one RW port, 4-lane (11-bit) write mask and 1-cycle registered read latency. It accepts independent read and write request channels, arbitrates them onto the one RW port, and returns read data through a 2-entry response buffer with valid/ready backpressure. After reset it runs a zero-initialisation sweep over the whole array. It sits between the cache-directory/data pipelines and the array macro.

## Interface
Parameters:
- ADDR_W, 7, array address width (DEPTH = 2**ADDR_W = 128)
- DATA_W, 44, array word width
- NUM_LANES, 4, write-mask lanes; LANE_W = DATA_W/NUM_LANES = 11
- SHOULD_RESET, 1, 1 = run zero-init sweep after reset

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- wr_valid / wr_ready  in / out  1  write request handshake
- wr_addr  in  ADDR_W  write address
- wr_mask  in  NUM_LANES  lane enables
- wr_data  in  DATA_W  write data
- rd_valid / rd_ready  in / out  1  read request handshake
- rd_addr  in  ADDR_W  read address
- resp_valid / resp_ready  out / in  1  read response handshake
- resp_data  out  DATA_W  read data
- init_done  out  1  high once array usable
- sram_en, sram_wmode  out  1  RW port enable / write mode
- sram_addr  out  ADDR_W; sram_wmask  out  NUM_LANES; sram_wdata  out  DATA_W
- sram_rdata  in  DATA_W  array read data, valid the cycle after a read enable

## Operation
- States: INIT, IDLE. Reset -> INIT if SHOULD_RESET else IDLE.
- INIT: each cycle sram_en=1, sram_wmode=1, sram_wmask=all-ones, sram_wdata=0, sram_addr=init counter (0..127, +1 per cycle). After writing 127 -> IDLE. wr_ready=rd_ready=0 throughout.
- IDLE: at most one array op per cycle. Read eligible iff rd_valid and credit available: fifo_count + inflight - pop < 2 (pop = resp_valid && resp_ready this cycle). Write eligible iff wr_valid.
- Arbitration: one eligible -> grant it. Both eligible -> grant per prio bit (0 = read), then toggle prio. Prio unchanged when no conflict. prio resets to 0.
- wr_ready / rd_ready = grant for that channel (combinational); handshake cycle drives sram_* combinationally: write -> en=1, wmode=1, mask/data/addr from request; read -> en=1, wmode=0, wmask=0, wdata=0.
- No grant: sram_en=0, other sram_* outputs 0.
- Read issued in cycle N sets inflight; in N+1 sram_rdata is pushed into the response FIFO. FIFO is 2-entry, in-order; resp_data = head entry.
- Write followed by read to the same address in the next cycle returns the new data (masked lanes only updated).

## Timing
- Read: accept cycle N -> resp_valid earliest N+2. With resp_ready held high, sustained 1 read/cycle.
- Write: committed at the clock edge closing the accept cycle; no response.
- init_done: 0 in reset and INIT; 1 from the first IDLE cycle (first cycle after reset release if SHOULD_RESET=0).
- Reset values: all outputs 0 (sram_*, wr_ready, rd_ready, resp_valid, resp_data, init_done); FIFO empty, inflight 0, init counter 0, prio 0.
- Reset asserted mid-operation: asynchronously drops sram_en and all readies; in-flight read and buffered responses discarded; sweep restarts on release.
- FIFO full with resp_ready low: rd_ready stays 0; writes still granted.

## Structure
- Package array_port_pkg: ADDR_W, DATA_W, NUM_LANES, LANE_W, DEPTH, state enum (INIT, IDLE).
- Sub-module array_resp_fifo: 2-entry valid/ready FIFO with count output; the rest lives in array_port_ctrl.

## Test plan
- Reset release, SHOULD_RESET=1 -> exactly 128 write cycles, addr 0..127, init_done rises cycle 129; then reading addr 5 returns 0.
- Write addr 0x10 data 0x0AB_CDE1_2345, mask 4'b1111; read 0x10 next cycle -> resp_data 0x0AB_CDE1_2345 two cycles after read accept.
- Masked write mask 4'b0010, data all-ones to addr 0x10 -> subsequent read returns bits [21:11] set, other lanes unchanged.
- resp_ready=0, rd_valid held high -> exactly 2 reads accepted, then rd_ready=0; wr_valid still accepted; raise resp_ready -> reads resume, responses in order.
- wr_valid and rd_valid both high 4 cycles, credit available -> grants alternate R,W,R,W.
- Assert reset_n=0 during INIT at counter 60 and during a read with inflight=1 -> outputs 0 immediately, no stale response after release, sweep restarts at 0.
